// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: groups the receiver-side write strobe, the consumer-side
// read handshake and the status outputs of uart_rx_fifo into one bundle.
// master = receiver/consumer side, slave = the FIFO itself.
interface uart_rx_fifo_if #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] data_rx;
    logic             WR2c;
    logic             rd_en;
    logic             ovf_clr;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;
    logic             empty;
    logic             full;
    logic [CW-1:0]    count;
    logic             overflow;
    logic [7:0]       drop_cnt;

    modport master (
        output data_rx, WR2c, rd_en, ovf_clr,
        input  rd_data, rd_valid, empty, full, count, overflow, drop_cnt
    );

    modport slave (
        input  data_rx, WR2c, rd_en, ovf_clr,
        output rd_data, rd_valid, empty, full, count, overflow, drop_cnt
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: circular byte buffer behind the UART receiver. Accepts one
// byte per WR2c strobe, lets the consumer pop at its own pace, and counts
// bytes dropped while full (saturating at 255).
// Optional feature: define UART_RX_FIFO_FWFT_EN for first-word-fall-through
// reads (head byte shown on rd_data whenever the FIFO is non-empty). Without
// it, rd_data is loaded on each accepted pop and rd_valid pulses one cycle.
// rst is synchronous and active-low.
module uart_rx_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst,
    uart_rx_fifo_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_empty;
    logic             r_full;
    logic [WIDTH-1:0] r_rd_data;
    logic             r_rd_valid;
    logic             r_overflow;
    logic [7:0]       r_drop_cnt;

    logic             w_pop_acc;
    logic             w_wr_acc;
    logic             w_drop;
    logic [CW-1:0]    w_count_nxt;
    logic [AW-1:0]    w_wr_ptr_nxt;
    logic [AW-1:0]    w_rd_ptr_nxt;
    logic             w_overflow_nxt;
    logic [7:0]       w_drop_cnt_nxt;
    logic [WIDTH-1:0] w_rd_data_nxt;
    logic             w_rd_valid_nxt;

    // Handshake decode and next-state computation for pointers, count and status.
    always_comb begin
        // A pop frees a slot in the same cycle, so a write to a full FIFO
        // paired with a pop is accepted rather than dropped.
        w_pop_acc = rst & bus.rd_en & ~r_empty;
        w_wr_acc  = rst & bus.WR2c & (~r_full | w_pop_acc);
        w_drop    = rst & bus.WR2c & r_full & ~w_pop_acc;

        case ({w_wr_acc, w_pop_acc})
            2'b10:   w_count_nxt = r_count + CNT_ONE;
            2'b01:   w_count_nxt = r_count - CNT_ONE;
            default: w_count_nxt = r_count;
        endcase

        if (w_wr_acc) begin
            w_wr_ptr_nxt = r_wr_ptr + PTR_ONE;
        end else begin
            w_wr_ptr_nxt = r_wr_ptr;
        end

        if (w_pop_acc) begin
            w_rd_ptr_nxt = r_rd_ptr + PTR_ONE;
        end else begin
            w_rd_ptr_nxt = r_rd_ptr;
        end

        // A drop in the same cycle as a clear wins: the drop is recorded fresh.
        if (w_drop) begin
            w_overflow_nxt = 1'b1;
            if (bus.ovf_clr) begin
                w_drop_cnt_nxt = 8'd1;
            end else if (r_drop_cnt == 8'd255) begin
                w_drop_cnt_nxt = r_drop_cnt;
            end else begin
                w_drop_cnt_nxt = r_drop_cnt + 8'd1;
            end
        end else if (bus.ovf_clr) begin
            w_overflow_nxt = 1'b0;
            w_drop_cnt_nxt = 8'd0;
        end else begin
            w_overflow_nxt = r_overflow;
            w_drop_cnt_nxt = r_drop_cnt;
        end

`ifdef UART_RX_FIFO_FWFT_EN
        // Registered head: load the byte that will sit at rd_ptr after this
        // edge. If that slot is being written right now, take it from the
        // input since the array does not hold it yet.
        w_rd_valid_nxt = (w_count_nxt != CNT_ZERO);
        if (w_count_nxt != CNT_ZERO) begin
            if (w_wr_acc && (w_rd_ptr_nxt == r_wr_ptr)) begin
                w_rd_data_nxt = bus.data_rx;
            end else begin
                w_rd_data_nxt = r_mem[w_rd_ptr_nxt];
            end
        end else begin
            w_rd_data_nxt = r_rd_data;
        end
`else
        // Registered read: data loads on the pop edge, valid for one cycle.
        w_rd_valid_nxt = w_pop_acc;
        if (w_pop_acc) begin
            w_rd_data_nxt = r_mem[r_rd_ptr];
        end else begin
            w_rd_data_nxt = r_rd_data;
        end
`endif
    end

    // Storage array: written on accepted writes only, never reset.
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= bus.data_rx;
        end
    end

    // Control and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_empty    <= 1'b1;
            r_full     <= 1'b0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
            r_overflow <= 1'b0;
            r_drop_cnt <= 8'd0;
        end else begin
            r_wr_ptr   <= w_wr_ptr_nxt;
            r_rd_ptr   <= w_rd_ptr_nxt;
            r_count    <= w_count_nxt;
            r_empty    <= (w_count_nxt == CNT_ZERO);
            r_full     <= (w_count_nxt == CNT_FULL);
            r_rd_data  <= w_rd_data_nxt;
            r_rd_valid <= w_rd_valid_nxt;
            r_overflow <= w_overflow_nxt;
            r_drop_cnt <= w_drop_cnt_nxt;
        end
    end

    assign bus.rd_data  = r_rd_data;
    assign bus.rd_valid = r_rd_valid;
    assign bus.empty    = r_empty;
    assign bus.full     = r_full;
    assign bus.count    = r_count;
    assign bus.overflow = r_overflow;
    assign bus.drop_cnt = r_drop_cnt;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed stimulus for uart_rx_fifo with a byte scoreboard.
// Stimulus pushes each byte it expects the FIFO to accept; a negedge monitor
// pops and compares whenever the FIFO presents a byte to the consumer.
module tb_uart_rx_fifo;
    localparam int DEPTH = 16;
    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;

    uart_rx_fifo_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

    uart_rx_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    logic [7:0]  sb[$];
    logic [7:0]  last_pop = 8'h00;
    int          m_count = 0;
    logic        m_ovf = 1'b0;
    int          m_drop = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Monitor: compare every byte handed to the consumer against the scoreboard.
    always @(negedge clk) begin
        logic take;
`ifdef UART_RX_FIFO_FWFT_EN
        take = rst && bus.rd_en && bus.rd_valid;
`else
        take = bus.rd_valid;
`endif
        if (take) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL spurious_read: got 0x%0h expected no byte", bus.rd_data);
            end else begin
                chk("rd_data", {24'd0, bus.rd_data}, {24'd0, sb.pop_front()});
                last_pop = bus.rd_data;
            end
        end
    end

    // One clock of stimulus; the reference model predicts acceptance and drops.
    task automatic cycle(input logic w, input logic [7:0] d, input logic r,
                         input logic c, input logic rs);
        bit pop, acc, drop;
        rst         = rs;
        bus.WR2c    = w;
        bus.data_rx = d;
        bus.rd_en   = r;
        bus.ovf_clr = c;
        if (!rs) begin
            m_count = 0;
            m_ovf   = 1'b0;
            m_drop  = 0;
            sb.delete();
        end else begin
            pop  = r && (m_count != 0);
            acc  = w && ((m_count != DEPTH) || pop);
            drop = w && (m_count == DEPTH) && !pop;
            if (acc) sb.push_back(d);
            m_count = m_count + (acc ? 1 : 0) - (pop ? 1 : 0);
            if (drop) begin
                m_ovf  = 1'b1;
                m_drop = c ? 1 : ((m_drop == 255) ? 255 : m_drop + 1);
            end else if (c) begin
                m_ovf  = 1'b0;
                m_drop = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic chk_status(input string tag);
        chk({tag, "_count"},    {26'd0, bus.count},   m_count);
        chk({tag, "_empty"},    {31'd0, bus.empty},   {31'd0, m_count == 0});
        chk({tag, "_full"},     {31'd0, bus.full},    {31'd0, m_count == DEPTH});
        chk({tag, "_overflow"}, {31'd0, bus.overflow}, {31'd0, m_ovf});
        chk({tag, "_drop_cnt"}, {24'd0, bus.drop_cnt}, m_drop);
    endtask

    initial begin
        bus.WR2c = 1'b0; bus.data_rx = 8'h00; bus.rd_en = 1'b0; bus.ovf_clr = 1'b0;
        #1;
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'hAA, 1'b1, 1'b0, 1'b0);
        idle(1);
        chk("rst_count",    {26'd0, bus.count},    32'd0);
        chk("rst_empty",    {31'd0, bus.empty},    32'd1);
        chk("rst_full",     {31'd0, bus.full},     32'd0);
        chk("rst_rd_valid", {31'd0, bus.rd_valid}, 32'd0);
        chk("rst_rd_data",  {24'd0, bus.rd_data},  32'd0);
        chk("rst_overflow", {31'd0, bus.overflow}, 32'd0);
        chk("rst_drop_cnt", {24'd0, bus.drop_cnt}, 32'd0);

        // Three writes on alternate cycles, then three back-to-back pops.
        cycle(1'b1, 8'h41, 1'b0, 1'b0, 1'b1); idle(1);
        cycle(1'b1, 8'h42, 1'b0, 1'b0, 1'b1); idle(1);
        cycle(1'b1, 8'h43, 1'b0, 1'b0, 1'b1);
        chk("three_count", {26'd0, bus.count}, 32'd3);
        chk("three_empty", {31'd0, bus.empty}, 32'd0);
        for (int k = 0; k < 3; k++) cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        idle(2);
        chk("drained_empty", {31'd0, bus.empty}, 32'd1);
        chk("drained_count", {26'd0, bus.count}, 32'd0);
        chk("drained_last",  {24'd0, last_pop},  32'h43);

        // Fill, then overflow with 0x5A which must not appear when draining.
        for (int k = 0; k < DEPTH; k++) cycle(1'b1, 8'h10 + 8'(k), 1'b0, 1'b0, 1'b1);
        chk("fill_full", {31'd0, bus.full}, 32'd1);
        cycle(1'b1, 8'h5A, 1'b0, 1'b0, 1'b1);
        chk("ovf_flag", {31'd0, bus.overflow}, 32'd1);
        chk("ovf_drop", {24'd0, bus.drop_cnt}, 32'd1);
        chk_status("ovf");
        for (int k = 0; k < DEPTH; k++) cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        idle(2);
        chk("fill_last", {24'd0, last_pop}, 32'h1F);
        cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        chk_status("clr");

        // Write and pop together while full: no drop, 0x77 comes out last.
        for (int k = 0; k < DEPTH; k++) cycle(1'b1, 8'h20 + 8'(k), 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 8'h77, 1'b1, 1'b0, 1'b1);
        chk("simul_count", {26'd0, bus.count},    32'd16);
        chk("simul_ovf",   {31'd0, bus.overflow}, 32'd0);
        for (int k = 0; k < DEPTH; k++) cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        idle(2);
        chk("simul_last", {24'd0, last_pop}, 32'h77);
        chk_status("simul_drained");

        // 300 drops saturate the counter; a clear colliding with a drop loses.
        for (int k = 0; k < DEPTH; k++) cycle(1'b1, 8'h60 + 8'(k), 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 300; k++) cycle(1'b1, 8'hEE, 1'b0, 1'b0, 1'b1);
        chk("sat_drop", {24'd0, bus.drop_cnt}, 32'd255);
        cycle(1'b1, 8'hEF, 1'b0, 1'b1, 1'b1);
        chk("clr_vs_drop_ovf",  {31'd0, bus.overflow}, 32'd1);
        chk("clr_vs_drop_cnt",  {24'd0, bus.drop_cnt}, 32'd1);
        for (int k = 0; k < DEPTH; k++) cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        idle(2);
        chk("sat_last", {24'd0, last_pop}, 32'h6F);

        // rd_en while empty is ignored; a following byte still reads correctly.
        for (int k = 0; k < 5; k++) begin
            cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
            chk("empty_rd_valid", {31'd0, bus.rd_valid}, 32'd0);
            chk("empty_rd_count", {26'd0, bus.count},    32'd0);
        end
        cycle(1'b1, 8'h99, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        idle(2);
        chk("after_empty_rd", {24'd0, last_pop}, 32'h99);

        // Reset mid-burst after seven writes; WR2c held during reset is ignored.
        for (int k = 0; k < 7; k++) cycle(1'b1, 8'hC0 + 8'(k), 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 8'hD0, 1'b0, 1'b0, 1'b0);
        chk("midrst_count", {26'd0, bus.count},    32'd0);
        chk("midrst_empty", {31'd0, bus.empty},    32'd1);
        chk("midrst_ovf",   {31'd0, bus.overflow}, 32'd0);
        cycle(1'b1, 8'hB5, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        idle(2);
        chk("midrst_first", {24'd0, last_pop}, 32'hB5);

`ifdef UART_RX_FIFO_FWFT_EN
        // Fall-through: written byte visible next cycle without rd_en.
        cycle(1'b1, 8'h31, 1'b0, 1'b0, 1'b1);
        chk("fwft_data",  {24'd0, bus.rd_data},  32'h31);
        chk("fwft_valid", {31'd0, bus.rd_valid}, 32'd1);
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        chk("fwft_clear", {31'd0, bus.rd_valid}, 32'd0);
        chk("fwft_hold",  {24'd0, bus.rd_data},  32'h31);
`endif

        idle(1);
        chk("sb_empty", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side byte buffer between the UART receiver and any byte consumer (LED driver, command parser). Captures each valid received byte, marked by the receiver's one-cycle `WR2c` strobe with `data_rx`, into a circular FIFO. It lets the consumer drain bytes at its own pace, and counts bytes dropped on overflow.

## Interface
- `DEPTH`, default 16: FIFO entries; power of two, ≥ 2.
- `WIDTH`, default 8: data width in bits.

- `clk` in 1: system clock; all logic on rising edge.
- `rst` in 1: reset; synchronous, active-low.
- `data_rx` in WIDTH: received byte, valid when `WR2c`=1.
- `WR2c` in 1: write strobe; one-cycle pulse per valid received byte.
- `rd_en` in 1: consumer read/pop request.
- `ovf_clr` in 1: clears `overflow` and `drop_cnt`.
- `rd_data` out WIDTH: read data.
- `rd_valid` out 1: `rd_data` is valid (meaning depends on mode, see Configuration).
- `empty` out 1: count == 0.
- `full` out 1: count == DEPTH.
- `count` out $clog2(DEPTH)+1: current occupancy, 0..DEPTH.
- `overflow` out 1: sticky; set when a byte was dropped.
- `drop_cnt` out 8: dropped-byte counter; saturates at 255.

## Operation
- Storage: DEPTH×WIDTH array, not reset.
- Pointers: write and read pointers, each $clog2(DEPTH) bits, wrap modulo DEPTH. Occupancy is held in a separate `count` register.
- Write accept: `WR2c`=1 and (`full`=0, or a pop is accepted in the same cycle). The accepted byte goes to mem[wr_ptr] and wr_ptr increments.
- Pop accept: `rd_en`=1 and `empty`=0. rd_ptr increments. `rd_en` while empty is ignored; there is no bypass of a same-cycle write into an empty FIFO.
- Count update: +1 on write only, −1 on pop only, unchanged on both.
- Drop: `WR2c`=1, `full`=1 and no same-cycle pop.
  - Byte discarded; pointers and count unchanged.
  - `overflow` ← 1.
  - `drop_cnt` ← min(`drop_cnt`+1, 255).
- `ovf_clr`=1: `overflow` ← 0 and `drop_cnt` ← 0. If a drop occurs in the same cycle, the drop wins: `overflow`=1, `drop_cnt`=1.
- Reset (any cycle, including mid-stream):
  - Pointers and count ← 0; `empty`=1, `full`=0.
  - `rd_data`=0, `rd_valid`=0, `overflow`=0, `drop_cnt`=0.
  - `WR2c` and `rd_en` are ignored while `rst`=0.
- `empty` and `full` are registered, or decoded from the registered count; they never glitch within a cycle.

## Timing
- Write latency: `WR2c` sampled at edge N → `count`, `empty` and `full` reflect it after edge N. The byte is poppable from cycle N+1.
- Standard mode, pop accepted at edge N:
  - `rd_data` ← mem[rd_ptr], and `rd_valid`=1 for exactly the cycle after edge N.
  - Otherwise `rd_valid`=0 and `rd_data` holds its last value.
- Back-to-back pops on consecutive cycles return consecutive bytes with `rd_valid` high continuously.
- Full throughput: one write and one pop per cycle, sustained.

## Configuration
- Macro `UART_RX_FIFO_FWFT_EN`.
- Defined (first-word-fall-through):
  - `rd_data` presents mem[rd_ptr] whenever `empty`=0, from a registered head.
  - `rd_valid` = ~`empty`.
  - `rd_en` acknowledges and pops the shown byte; the next byte appears on the cycle after the pop edge.
  - A write into an empty FIFO at edge N shows on `rd_data` with `rd_valid`=1 in cycle N+1.
  - When empty, `rd_data` holds its last value.
- Undefined: standard registered-read behaviour as in Timing.

## Test plan
- Reset, then 3 writes (0x41, 0x42, 0x43) on alternate cycles → `count`=3, `empty`=0. Then 3 pops → `rd_data` 0x41, 0x42, 0x43 with `rd_valid` pulses; finally `empty`=1, `count`=0.
- Fill 16 bytes, then write 0x5A → `full`=1, `overflow`=1, `drop_cnt`=1, 0x5A absent. Draining returns the original 16 in order.
- With `full`=1, assert `WR2c`=1 (0x77) and `rd_en`=1 together → no drop, `count` stays 16. 0x77 is the last byte out.
- 300 writes to a full FIFO → `drop_cnt`=255 (saturated). Then `ovf_clr` asserted in the same cycle as another drop → `overflow`=1, `drop_cnt`=1.
- `rd_en` held while empty for 5 cycles → `rd_valid`=0, `count`=0, no pointer movement. Also: `rst`=0 asserted mid-burst after 7 writes → next cycle `count`=0, `empty`=1, `overflow`=0.
- With `UART_RX_FIFO_FWFT_EN`: write 0x31 at edge N → `rd_data`=0x31 and `rd_valid`=1 in cycle N+1 without `rd_en`. A pop then clears `rd_valid` when empty.
